multicycle_control: RTL
=======================

# multicycle_control

Multicycle control unit that sequences the RV32I datapath through IF/ID/EX/MEM/WB one instruction at a time. It drives every datapath control input (PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC) from its state register and the current instruction word. It also drives data-memory strobes with a ready handshake and counts retired instructions. It sits beside the datapath; `instr` and `Zero` come back from the datapath/instruction memory.

## Interface
- INSTRET_WIDTH, 32, width of retired-instruction counter
- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous reset, active-high
- instr  input  32  current instruction word, stable from IF through WB
- Zero  input  1  datapath ALU zero flag, combinational
- mem_ready  input  1  data memory completes the access this cycle
- PCSrc  output  1  select branch target for next PC
- ALUSrc  output  1  ALU operand 2 = immediate
- RegWrite  output  1  register-file write strobe
- MemToReg  output  1  write-back source = dReadData
- ALUCtrl  output  4  ALU operation code
- loadPC  output  1  PC update strobe
- MemRead  output  1  data memory read request
- MemWrite  output  1  data memory write request
- state  output  3  current state, debug
- illegal  output  1  one-cycle pulse, unsupported instruction decoded
- instret  output  INSTRET_WIDTH  retired-instruction count

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 unreachable, map to IF.
- IF->ID->EX unconditional. EX->MEM for load (0000011, funct3 010) or store (0100011, funct3 010); otherwise EX->WB. MEM holds while mem_ready=0, MEM->WB when mem_ready=1. WB->IF.
- Supported: R-type 0110011, I-ALU 0010011, LW, SW, BEQ/BNE (1100011, funct3 000/001). Anything else is illegal: in ID pulse illegal=1, take ID->EX->WB path as NOP (no RegWrite, no memory strobes, PCSrc=0).
- ALUCtrl encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101. R/I decode by funct3; funct7[5] selects SUB (R only) and SRA (R and I). LW/SW use ADD; branches use SUB; illegal uses ADD.
- ALUSrc=1 for I-ALU, LW, SW; else 0. ALUSrc/ALUCtrl are combinational decode of instr, valid in all states.
- EX: register branch_taken = is_beq & Zero | is_bne & ~Zero.
- MEM: MemWrite=1 (SW) or MemRead=1 (LW) every MEM cycle until mem_ready.
- WB: loadPC=1; PCSrc=branch_taken; RegWrite=1 for R, I-ALU, LW; MemToReg=1 and MemRead=1 for LW; instret increments (illegal NOPs included).
- instret wraps modulo 2^INSTRET_WIDTH.

## Timing
- Reset: state=IF, branch_taken=0, instret=0, illegal=0. While rst=1, RegWrite, MemWrite, MemRead, loadPC and PCSrc are forced 0 regardless of state.
- Reset asserted mid-instruction: no strobe in that cycle; next cycle state=IF, instruction abandoned, instret unchanged except cleared.
- Latency: R/I/branch/illegal = 4 cycles (IF,ID,EX,WB); LW/SW = 5 + wait cycles (mem_ready low cycles in MEM).
- loadPC high exactly one cycle per instruction, in WB; PC update lands on the WB->IF edge.
- RegWrite only in WB; MemWrite only in MEM; never both in one cycle.
- Zero sampled only on the EX-cycle edge; later Zero changes ignored.
- mem_ready outside MEM ignored.

## Test plan
- Reset then add x3,x1,x2 (0x002081B3): states 0,1,2,4; ALUCtrl=0010, ALUSrc=0; RegWrite=1 and loadPC=1 only in WB; instret=1.
- sub (0x402081B3) then addi: ALUCtrl=0110 then 0010 with ALUSrc=1; both 4-cycle; instret=2.
- lw x5,8(x1) (0x0080A283) with mem_ready low 2 cycles: MEM held 3 cycles with MemRead=1; WB has MemToReg=1, RegWrite=1; total 7 cycles.
- sw x2,4(x1) (0x0020A223), mem_ready=1: MemWrite=1 single MEM cycle; RegWrite never 1.
- beq x1,x2,+8 (0x00208463) with Zero=1 in EX, then Zero=0 rerun: PCSrc=1 then 0 in WB; ALUCtrl=0110; no RegWrite.
- Opcode 0x0000007F: illegal pulses in ID, no strobes except loadPC in WB, PCSrc=0; rst asserted during a lw MEM cycle -> MemRead=0 that cycle, state=IF next, instret=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: steps one instruction at a time through
// IF/ID/EX/MEM/WB, decodes the datapath controls from the instruction word,
// handshakes data-memory accesses with mem_ready and counts retired instructions.
module multicycle_control #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              instr,
    input  logic                     Zero,
    input  logic                     mem_ready,
    output logic                     PCSrc,
    output logic                     ALUSrc,
    output logic                     RegWrite,
    output logic                     MemToReg,
    output logic [3:0]               ALUCtrl,
    output logic                     loadPC,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic [2:0]               state,
    output logic                     illegal,
    output logic [INSTRET_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_t                   state_q, state_d;
    logic                     branch_taken_q, branch_taken_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_legal;

    // Register numbers and immediates belong to the datapath, not to control
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Instruction class decode; anything outside the supported subset is illegal
    always_comb begin
        is_r     = (opcode == 7'b0110011);
        is_i     = (opcode == 7'b0010011);
        is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
        is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
        is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
        is_legal = is_r | is_i | is_lw | is_sw | is_beq | is_bne;
    end

    // ALU operand/operation decode, purely from the instruction so it holds in every state
    always_comb begin
        ALUSrc  = is_i | is_lw | is_sw;
        ALUCtrl = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  ALUCtrl = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  ALUCtrl = ALU_SLL;
                3'b010:  ALUCtrl = ALU_SLT;
                3'b011:  ALUCtrl = ALU_SLT;
                3'b100:  ALUCtrl = ALU_XOR;
                3'b101:  ALUCtrl = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  ALUCtrl = ALU_OR;
                default: ALUCtrl = ALU_AND;
            endcase
        end else if (is_beq || is_bne) begin
            ALUCtrl = ALU_SUB;
        end
    end

    // Next-state and strobe generation; reset suppresses every strobe in its own cycle
    always_comb begin
        state_d        = state_q;
        branch_taken_d = branch_taken_q;
        instret_d      = instret_q;
        PCSrc          = 1'b0;
        RegWrite       = 1'b0;
        MemToReg       = 1'b0;
        loadPC         = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        illegal        = 1'b0;

        case (state_q)
            S_IF: begin
                state_d = S_ID;
            end
            S_ID: begin
                illegal = ~is_legal;
                state_d = S_EX;
            end
            S_EX: begin
                branch_taken_d = (is_beq & Zero) | (is_bne & ~Zero);
                state_d        = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ready) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                loadPC    = 1'b1;
                PCSrc     = branch_taken_q;
                RegWrite  = is_r | is_i | is_lw;
                MemToReg  = is_lw;
                MemRead   = is_lw;
                instret_d = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
                state_d   = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        if (rst) begin
            PCSrc    = 1'b0;
            RegWrite = 1'b0;
            loadPC   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    // State, latched branch decision and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IF;
            branch_taken_q <= 1'b0;
            instret_q      <= '0;
        end else begin
            state_q        <= state_d;
            branch_taken_q <= branch_taken_d;
            instret_q      <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
